// File: rtl/histo_reader.sv
// histo_reader: streams a histogram readout frame over a byte-wide
// valid/ready link.
//
// Frame: 0xA5, 0x5A, NHIST photon-count words, NIPI inter-photon-interval
// words (index 0 first, each word MSB byte first), then an optional XOR
// checksum of the payload bytes.
//
// Build option:
//   HISTO_READER_CKSUM_EN - when defined, appends the XOR of all payload
//                           bytes as the final frame byte (CKSUM state).
//
// Ports:
//   clkin        - clock, all state changes on the rising edge
//   resetn       - asynchronous active-low reset
//   start        - readout request, sampled only in IDLE
//   clear_after  - sampled with start; request a histogram clear after the frame
//   histo_flat   - NHIST 32-bit words, word i at [32i+31:32i]
//   ipihist_flat - NIPI 32-bit words, word i at [32i+31:32i]
//   tx_data      - frame byte
//   tx_valid     - tx_data valid
//   tx_ready     - sink accepts the byte when tx_valid && tx_ready at an edge
//   resethist    - one-cycle clear pulse to the histogram counter
//   busy         - high in every state except IDLE
module histo_reader #(
    parameter int NHIST = 8,
    parameter int NIPI  = 64
) (
    input  logic                  clkin,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  clear_after,
    input  logic [32*NHIST-1:0]   histo_flat,
    input  logic [32*NIPI-1:0]    ipihist_flat,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  resethist,
    output logic                  busy
);

    localparam int NW    = NHIST + NIPI;
    localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR0  = 3'd1,
        HDR1  = 3'd2,
        LOAD  = 3'd3,
        BYTE  = 3'd4,
`ifdef HISTO_READER_CKSUM_EN
        CKSUM = 3'd5,
`endif
        CLEAR = 3'd6
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [1:0]        byte_cnt;
    logic [31:0]       hold;
    logic              clear_lat;
    logic [32*NW-1:0]  all_flat;
    logic [31:0]       cur_word;
    logic [7:0]        next_byte;
    logic              accept;
`ifdef HISTO_READER_CKSUM_EN
    logic [7:0]        cksum;
`endif

    // Histo words occupy indices 0..NHIST-1, ipihist words follow.
    assign all_flat = {ipihist_flat, histo_flat};
    assign cur_word = all_flat[32*idx +: 32];
    assign accept   = tx_valid && tx_ready;

    // Byte that follows the one currently on tx_data within the held word.
    always_comb begin
        next_byte = hold[7:0];
        case (byte_cnt)
            2'd0:    next_byte = hold[23:16];
            2'd1:    next_byte = hold[15:8];
            2'd2:    next_byte = hold[7:0];
            default: next_byte = hold[31:24];
        endcase
    end

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            tx_valid  <= 1'b0;
            tx_data   <= 8'h00;
            resethist <= 1'b0;
            busy      <= 1'b0;
            idx       <= '0;
            byte_cnt  <= 2'd0;
            hold      <= 32'h0;
            clear_lat <= 1'b0;
`ifdef HISTO_READER_CKSUM_EN
            cksum     <= 8'h00;
`endif
        end else begin
            resethist <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= HDR0;
                        clear_lat <= clear_after;
                        tx_valid  <= 1'b1;
                        tx_data   <= 8'hA5;
                        busy      <= 1'b1;
                        idx       <= '0;
                    end
                end
                HDR0: begin
`ifdef HISTO_READER_CKSUM_EN
                    cksum <= 8'h00;
`endif
                    if (accept) begin
                        state   <= HDR1;
                        tx_data <= 8'h5A;
                    end
                end
                HDR1: begin
                    if (accept) begin
                        state    <= LOAD;
                        tx_valid <= 1'b0;
                    end
                end
                LOAD: begin
                    // Snapshot: later input changes cannot disturb this word.
                    hold     <= cur_word;
                    tx_data  <= cur_word[31:24];
                    tx_valid <= 1'b1;
                    byte_cnt <= 2'd0;
                    state    <= BYTE;
                end
                BYTE: begin
                    if (accept) begin
`ifdef HISTO_READER_CKSUM_EN
                        cksum <= cksum ^ tx_data;
`endif
                        if (byte_cnt == 2'd3) begin
                            if (idx == LAST_IDX) begin
`ifdef HISTO_READER_CKSUM_EN
                                // Include the byte being accepted right now.
                                state   <= CKSUM;
                                tx_data <= cksum ^ tx_data;
`else
                                tx_valid <= 1'b0;
                                if (clear_lat) begin
                                    state     <= CLEAR;
                                    resethist <= 1'b1;
                                end else begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end
`endif
                            end else begin
                                idx      <= idx + 1'b1;
                                state    <= LOAD;
                                tx_valid <= 1'b0;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                            tx_data  <= next_byte;
                        end
                    end
                end
`ifdef HISTO_READER_CKSUM_EN
                CKSUM: begin
                    if (accept) begin
                        tx_valid <= 1'b0;
                        if (clear_lat) begin
                            state     <= CLEAR;
                            resethist <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
`endif
                CLEAR: begin
                    // resethist was raised on entry; it drops on this edge.
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_histo_reader.sv
// tb_histo_reader: directed self-checking bench for histo_reader.
module tb_histo_reader;

    localparam int NH = 8;
    localparam int NI = 64;
    localparam int NW = NH + NI;
`ifdef HISTO_READER_CKSUM_EN
    localparam int FL = 2 + 4*NW + 1;
`else
    localparam int FL = 2 + 4*NW;
`endif

    logic              clkin = 1'b0;
    logic              resetn = 1'b0;
    logic              start = 1'b0;
    logic              clear_after = 1'b0;
    logic [32*NH-1:0]  histo_flat;
    logic [32*NI-1:0]  ipihist_flat;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              resethist;
    logic              busy;

    int errors = 0;
    int checks = 0;

    // tx_ready driver controls
    bit   rand_ready = 1'b0;
    logic ready_val  = 1'b1;

    // monitor state
    logic [7:0] rx_q[$];
    int         acc_q[$];
    int         cyc = 0;
    int         stall_viol = 0;
    int         rh_cnt = 0;
    int         rh_cyc = -1;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    histo_reader #(.NHIST(NH), .NIPI(NI)) dut (
        .clkin       (clkin),
        .resetn      (resetn),
        .start       (start),
        .clear_after (clear_after),
        .histo_flat  (histo_flat),
        .ipihist_flat(ipihist_flat),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .resethist   (resethist),
        .busy        (busy)
    );

    always #5 clkin = ~clkin;

    // tx_ready changes 1 time unit after each rising edge.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clkin);
            #1;
            tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
        end
    end

    // Negedge monitor: captures accepted bytes, stall stability, resethist.
    initial begin
        forever begin
            @(negedge clkin);
            cyc++;
            if (!resetn) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data))
                    stall_viol++;
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
                if (tx_valid && tx_ready) begin
                    rx_q.push_back(tx_data);
                    acc_q.push_back(cyc);
                end
                if (resethist) begin
                    rh_cnt++;
                    rh_cyc = cyc;
                end
            end
        end
    end

    function automatic logic [7:0] exp_byte(input int n);
        logic [31:0] w;
        int p;
        if (n == 0) return 8'hA5;
        if (n == 1) return 8'h5A;
        if (n >= 2 + 4*NW) return 8'h08;   // XOR of default payload
        p = n - 2;
        if (p / 4 < NH) w = 32'(p / 4 + 1);
        else            w = 32'h100 + 32'(p / 4 - NH);
        return w[31 - 8*(p % 4) -: 8];
    endfunction

    // Number of bytes in rx_q[base +: FL] differing from the default frame.
    function automatic int stream_diffs(input int base, output int first_bad);
        int n;
        n = 0;
        first_bad = -1;
        for (int i = 0; i < FL; i++) begin
            if (base + i >= rx_q.size() || rx_q[base + i] !== exp_byte(i)) begin
                if (first_bad < 0) first_bad = i;
                n++;
            end
        end
        return n;
    endfunction

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic set_pattern();
        for (int k = 0; k < NH; k++) histo_flat[32*k +: 32] = 32'(k + 1);
        for (int k = 0; k < NI; k++) ipihist_flat[32*k +: 32] = 32'h100 + 32'(k);
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clkin);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_start(input logic clr);
        tick();
        start = 1'b1;
        clear_after = clr;
        tick();
        start = 1'b0;
        clear_after = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #2;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
        checks++; if (resethist !== 1'b0) begin errors++; $display("FAIL reset_resethist got=%b want=0", resethist); end
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_frame();
        bit ok;
        int nd, fb;
        rx_q.delete(); acc_q.delete(); rh_cnt = 0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clkin);
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin errors++; $display("FAIL first_byte valid=%b data=%h want valid=1 data=a5", tx_valid, tx_data); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_frame got=%b want=1", busy); end
        wait_idle(FL + 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL frame_timeout busy still high"); end
        checks++; if (rx_q.size() != FL) begin errors++; $display("FAIL frame_len got=%0d want=%0d", rx_q.size(), FL); end
        nd = stream_diffs(0, fb);
        checks++; if (nd != 0) begin errors++; $display("FAIL frame_stream diffs=%0d first_index=%0d want 0 diffs", nd, fb); end
        checks++; if (rx_q.size() > 5 && {rx_q[2], rx_q[3], rx_q[4], rx_q[5]} !== 32'h00000001) begin errors++; $display("FAIL histo_word0 got=%h%h%h%h want=00000001", rx_q[2], rx_q[3], rx_q[4], rx_q[5]); end
`ifdef HISTO_READER_CKSUM_EN
        checks++; if (rx_q.size() == FL && rx_q[FL-1] !== 8'h08) begin errors++; $display("FAIL checksum got=%h want=08", rx_q[FL-1]); end
        checks++; if (rx_q.size() == FL && rx_q[FL-2] !== 8'h3F) begin errors++; $display("FAIL last_payload got=%h want=3f", rx_q[FL-2]); end
`else
        checks++; if (rx_q.size() == FL && rx_q[FL-1] !== 8'h3F) begin errors++; $display("FAIL last_payload got=%h want=3f", rx_q[FL-1]); end
`endif
        checks++; if (rh_cnt != 0) begin errors++; $display("FAIL no_clear resethist_cycles=%0d want=0", rh_cnt); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int nd, fb;
        rx_q.delete(); acc_q.delete(); stall_viol = 0;
        rand_ready = 1'b1;
        pulse_start(1'b0);
        wait_idle(8 * FL, ok);
        rand_ready = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout busy still high"); end
        checks++; if (rx_q.size() != FL) begin errors++; $display("FAIL bp_len got=%0d want=%0d", rx_q.size(), FL); end
        nd = stream_diffs(0, fb);
        checks++; if (nd != 0) begin errors++; $display("FAIL bp_stream diffs=%0d first_index=%0d want 0 diffs", nd, fb); end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stall_stable violations=%0d want=0", stall_viol); end
    endtask

    task automatic test_clear();
        bit ok;
        rx_q.delete(); acc_q.delete(); rh_cnt = 0; rh_cyc = -1;
        pulse_start(1'b1);
        wait_idle(FL + 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL clear_timeout busy still high"); end
        checks++; if (rh_cnt != 1) begin errors++; $display("FAIL clear_pulse_len cycles=%0d want=1", rh_cnt); end
        checks++; if (acc_q.size() != FL || rh_cyc != acc_q[acc_q.size()-1] + 1) begin errors++; $display("FAIL clear_timing resethist_cyc=%0d last_accept_cyc=%0d want last+1", rh_cyc, (acc_q.size() > 0) ? acc_q[acc_q.size()-1] : -1); end
    endtask

    task automatic test_snapshot();
        bit ok, seen;
        histo_flat[31:0] = 32'h11223344;
        rx_q.delete(); acc_q.delete();
        pulse_start(1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clkin);
            if (busy && !tx_valid) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL snap_load_seen got=0 want=1"); end
        tick();
        histo_flat[31:0] = 32'hFFFFFFFF;
        wait_idle(FL + 200, ok);
        histo_flat[31:0] = 32'h00000001;
        checks++; if (!ok || rx_q.size() != FL) begin errors++; $display("FAIL snap_len got=%0d want=%0d", rx_q.size(), FL); end
        checks++; if (rx_q.size() > 9 && {rx_q[2], rx_q[3], rx_q[4], rx_q[5]} !== 32'h11223344) begin errors++; $display("FAIL snap_word0 got=%h%h%h%h want=11223344", rx_q[2], rx_q[3], rx_q[4], rx_q[5]); end
        checks++; if (rx_q.size() > 9 && {rx_q[6], rx_q[7], rx_q[8], rx_q[9]} !== 32'h00000002) begin errors++; $display("FAIL snap_word1 got=%h%h%h%h want=00000002", rx_q[6], rx_q[7], rx_q[8], rx_q[9]); end
    endtask

    task automatic test_reset_midframe();
        bit ok, hit;
        int nd, fb;
        rx_q.delete(); acc_q.delete();
        pulse_start(1'b0);
        hit = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clkin);
            if (rx_q.size() >= 100) begin hit = 1'b1; break; end
        end
        checks++; if (!hit) begin errors++; $display("FAIL mid_reach_100 got=%0d want>=100", rx_q.size()); end
        #2;
        resetn = 1'b0;
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_tx_valid got=%b want=0", tx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got=%b want=0", busy); end
        rx_q.delete(); acc_q.delete();
        tick();
        resetn = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clkin);
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin errors++; $display("FAIL post_reset_start valid=%b data=%h want valid=1 data=a5", tx_valid, tx_data); end
        wait_idle(FL + 200, ok);
        nd = stream_diffs(0, fb);
        checks++; if (!ok || rx_q.size() != FL || nd != 0) begin errors++; $display("FAIL post_reset_frame len=%0d diffs=%0d want len=%0d diffs=0", rx_q.size(), nd, FL); end
    endtask

    task automatic test_back_to_back();
        bit ok, got2;
        int nd, fb;
        rx_q.delete(); acc_q.delete();
        tick();
        start = 1'b1;
        got2 = 1'b0;
        for (int i = 0; i < 3 * FL; i++) begin
            @(negedge clkin);
            if (rx_q.size() >= 2 * FL) begin got2 = 1'b1; break; end
        end
        start = 1'b0;
        checks++; if (!got2) begin errors++; $display("FAIL b2b_two_frames bytes=%0d want>=%0d", rx_q.size(), 2 * FL); end
        checks++; if (acc_q.size() > FL && acc_q[FL] - acc_q[FL-1] != 2) begin errors++; $display("FAIL b2b_gap cycles=%0d want=2", acc_q[FL] - acc_q[FL-1]); end
        nd = stream_diffs(FL, fb);
        checks++; if (nd != 0) begin errors++; $display("FAIL b2b_second_frame diffs=%0d first_index=%0d want 0 diffs", nd, fb); end
        wait_idle(FL + 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout busy still high"); end
    endtask

    initial begin
        histo_flat   = '0;
        ipihist_flat = '0;
        set_pattern();
        test_reset();
        test_frame();
        test_backpressure();
        test_clear();
        test_snapshot();
        test_reset_midframe();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/histo_reader.md
HISTO_READER -- requirements
Module: histo_reader

Interface
REQ-001 SHALL have parameter NHIST, default 8: number of photon-count words read from histo_flat.
REQ-002 SHALL have parameter NIPI, default 64: number of inter-photon-interval words read from ipihist_flat.
REQ-003 SHALL have port clkin  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  readout request, sampled in IDLE only.
REQ-006 SHALL have port clear_after  input  1  sampled with start; 1 = clear histograms after the frame.
REQ-007 SHALL have port histo_flat  input  32*NHIST  word i at bits [32i+31:32i].
REQ-008 SHALL have port ipihist_flat  input  32*NIPI  word i at bits [32i+31:32i].
REQ-009 SHALL have port tx_data  output  8  frame byte.
REQ-010 SHALL have port tx_valid  output  1  tx_data valid.
REQ-011 SHALL have port tx_ready  input  1  sink accepts the byte when tx_valid and tx_ready are both 1 at a clock edge.
REQ-012 SHALL have port resethist  output  1  one-cycle clear request to the histogram counter.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement states IDLE, HDR0, HDR1, LOAD, BYTE, CKSUM, CLEAR.
REQ-015 SHALL move IDLE->HDR0 on the edge where start=1, latching clear_after; tx_valid rises the next cycle with tx_data=0xA5.
REQ-016 SHALL send frame: 0xA5, 0x5A, then NHIST histo words (index 0 first), then NIPI ipihist words, each word MSB byte first, then checksum (REQ-028).
REQ-017 SHALL advance HDR0->HDR1->LOAD, each on acceptance of its byte.
REQ-018 SHALL in LOAD (one cycle, tx_valid=0) snapshot the current 32-bit word into a hold register, then enter BYTE; changes to inputs after the snapshot do not alter the transmitted word.
REQ-019 SHALL in BYTE emit hold[31:24], [23:16], [15:8], [7:0], in that order, one byte per acceptance.
REQ-020 SHALL hold tx_data stable and tx_valid high while tx_valid=1 and tx_ready=0.
REQ-021 SHALL use a word index of 0..NHIST+NIPI-1; after the last byte of word NHIST+NIPI-1 go to CKSUM (or to CLEAR/IDLE per REQ-029), else back to LOAD with index+1.
REQ-022 SHALL in CLEAR drive resethist=1 for exactly one cycle if the latched clear_after=1, then return to IDLE; if clear_after=0, skip CLEAR and return straight to IDLE.
REQ-023 SHALL ignore start while busy=1; a start asserted in the same cycle the FSM returns to IDLE is ignored, start is honoured from the following cycle.
REQ-024 SHALL deassert tx_valid in IDLE, LOAD and CLEAR.
REQ-025 SHALL make frame length 2+4*(NHIST+NIPI) bytes plus the checksum byte when enabled (291 bytes with defaults and checksum enabled).

Reset
REQ-026 SHALL on resetn=0, immediately and regardless of state: state=IDLE, tx_valid=0, tx_data=0x00, resethist=0, busy=0, word index=0, hold=0, checksum=0; any partial frame is abandoned.
REQ-027 SHALL accept start on the first rising edge of clkin after resetn is released.

Configuration
REQ-028 SHALL, when HISTO_READER_CKSUM_EN is defined, accumulate the XOR of all payload bytes (headers excluded), clear it in HDR0, and send it as the final byte in CKSUM.
REQ-029 SHALL, when HISTO_READER_CKSUM_EN is undefined, omit CKSUM state and checksum logic, ending the frame after the last payload byte (290 bytes with defaults).

Verification
REQ-030 SHALL cover: histo word k = k+1, ipihist word k = 0x100+k, tx_ready=1, start pulse -> 0xA5,0x5A,00,00,00,01,... ,00,00,01,3F, checksum = XOR of payload, 291 bytes, back-to-back.
REQ-031 SHALL cover: tx_ready toggled randomly 50% -> identical byte stream to REQ-030; tx_data never changes while tx_valid=1 and tx_ready=0.
REQ-032 SHALL cover: clear_after=1 -> resethist high exactly one cycle after the last byte is accepted; clear_after=0 -> resethist never rises.
REQ-033 SHALL cover: histo word 0 changes from 0x11223344 to 0xFFFFFFFF one cycle after its LOAD -> bytes 11,22,33,44 sent.
REQ-034 SHALL cover: resetn pulsed low at byte 100 -> tx_valid=0 and busy=0 immediately; a new start produces a complete frame beginning with 0xA5.
REQ-035 SHALL cover: start held high throughout -> frames repeat with one IDLE cycle of tx_valid=0 between them; build without HISTO_READER_CKSUM_EN -> 290-byte frames.
